// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, MSB-first bit stream out.
// Optional even-parity bit after each word when SER_PARITY_EN is defined.
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bcnt;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state == SHIFT) && (bcnt == '0);

  // Ready comes from registered state only, so there is no valid->ready path.
`ifdef SER_PARITY_EN
  logic par;
  assign din_ready = (state == IDLE) || (state == PARITY);
`else
  assign din_ready = (state == IDLE) || last_bit;
`endif

  assign accept = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = SHIFT;
      SHIFT: begin
        if (last_bit) begin
`ifdef SER_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = accept ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PARITY: state_nx = accept ? SHIFT : IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // bcnt holds at zero after the last bit so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      bcnt <= '0;
`ifdef SER_PARITY_EN
      par  <= 1'b0;
`endif
    end else if (accept) begin
      sreg <= din;
      bcnt <= LAST_IDX;
`ifdef SER_PARITY_EN
      par  <= ^din;
`endif
    end else if (state == SHIFT) begin
      sreg <= sreg << 1;
      if (bcnt != '0) bcnt <= bcnt - CW'(1);
    end
  end

  always_comb begin
    ser_out = 1'b0;
    if (state == SHIFT) ser_out = sreg[WIDTH-1];
`ifdef SER_PARITY_EN
    else if (state == PARITY) ser_out = par;
`endif
  end

  assign ser_valid = (state != IDLE);
  assign busy      = ser_valid;
  assign ser_first = (state == SHIFT) && (bcnt == LAST_IDX);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer (WIDTH=8); parity-cycle checks follow SER_PARITY_EN.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, ser_out, ser_valid, ser_first, busy;

  int total = 0;
  int bad   = 0;
  logic [15:0] stream;

  bit_serializer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_first(ser_first), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out"},   32'(ser_out),   32'd0);
    chk({tag, "_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, "_first"}, 32'(ser_first), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_ready"}, 32'(din_ready), 32'd1);
  endtask

  // Checks one word starting in the current cycle and ends one cycle past it.
  // With scramble set, din carries junk while not ready and nxt while ready.
  task automatic check_word(input string tag, input logic [7:0] w, input logic pbit,
                            input bit scramble, input logic [7:0] nxt);
    logic rdy_exp;
    for (int i = 0; i < 8; i++) begin
`ifdef SER_PARITY_EN
      rdy_exp = 1'b0;
`else
      rdy_exp = (i == 7);
`endif
      chk({tag, "_bit"},   32'(ser_out),   32'(w[7-i]));
      chk({tag, "_valid"}, 32'(ser_valid), 32'd1);
      chk({tag, "_busy"},  32'(busy),      32'd1);
      chk({tag, "_first"}, 32'(ser_first), 32'(i == 0));
      chk({tag, "_ready"}, 32'(din_ready), 32'(rdy_exp));
      stream = {stream[14:0], ser_out};
      if (scramble) din = rdy_exp ? nxt : 8'(i * 37 + 11);
      tick();
    end
`ifdef SER_PARITY_EN
    chk({tag, "_par"},       32'(ser_out),   32'(pbit));
    chk({tag, "_par_valid"}, 32'(ser_valid), 32'd1);
    chk({tag, "_par_first"}, 32'(ser_first), 32'd0);
    chk({tag, "_par_ready"}, 32'(din_ready), 32'd1);
    if (scramble) din = nxt;
    tick();
`else
    chk({tag, "_pbit_known"}, 32'(pbit !== 1'bx), 32'd1);
`endif
  endtask

  initial begin
    stream = '0;
    // Reset with a word offered: nothing captured.
    rst = 1'b1; din_valid = 1'b1; din = 8'hFF;
    tick(); tick();
    rst = 1'b0; din_valid = 1'b0;
    chk_idle("reset");
    tick();
    chk_idle("reset_nocap");

    // Single word 0xB4.
    din = 8'hB4; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check_word("single", 8'hB4, 1'b0, 1'b0, 8'h00);
    chk_idle("single_after");

    // Back-to-back 0xB4 then 0x2D with valid held high.
    stream = '0;
    din = 8'hB4; din_valid = 1'b1;
    tick();
    din = 8'h2D;
    check_word("b2b_a", 8'hB4, 1'b0, 1'b0, 8'h00);
    din_valid = 1'b0;
    check_word("b2b_b", 8'h2D, 1'b0, 1'b0, 8'h00);
    chk("b2b_stream", 32'(stream), 32'b1011010000101101);
    chk_idle("b2b_after");

    // 0xB4 (parity 0) followed directly by 0x07 (parity 1).
    din = 8'hB4; din_valid = 1'b1;
    tick();
    din = 8'h07;
    check_word("par_a", 8'hB4, 1'b0, 1'b0, 8'h00);
    din_valid = 1'b0;
    check_word("par_b", 8'h07, 1'b1, 1'b0, 8'h00);
    chk_idle("par_after");

    // Mid-word reset, then a fresh word 0x81.
    din = 8'hB4; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("mid_c1", 32'(ser_out), 32'd1);
    tick();
    chk("mid_c2", 32'(ser_out), 32'd0);
    tick();
    chk("mid_c3", 32'(ser_out), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("mid_rst");
    din = 8'h81; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    check_word("mid_new", 8'h81, 1'b0, 1'b0, 8'h00);
    chk_idle("mid_after");

    // Stall: din churns every cycle; only the word present while ready is taken.
    din = 8'hC3; din_valid = 1'b1;
    tick();
    check_word("stall_a", 8'hC3, 1'b0, 1'b1, 8'h5A);
    din_valid = 1'b0;
    din = 8'hFF;
    check_word("stall_b", 8'h5A, 1'b0, 1'b0, 8'h00);
    chk_idle("stall_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
